// File: rtl/serial_deser.sv
// serial_deser: receiver for the board's LSB-first, button-strobed serial link.
// Frame = start(0) + WIDTH data bits + stop(1); the last good word is shown on
// ledR and two seven-segment digits, and the status is shown on ledG.
// Optional macro SERIAL_DESER_PARITY_EN adds an even-parity bit before the stop bit.

// hex_to_7seg: active-low segment decoder, bit order {g,f,e,d,c,b,a}.
module hex_to_7seg (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Lookup of the segment pattern for one hex digit.
  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

module serial_deser #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       button0,
  input  logic       button2,
  input  logic       button1,
  input  logic       switch8,
  output logic [7:0] ledR,
  output logic [7:0] ledG,
  output logic [6:0] hex,
  output logic [6:0] hex2
);

`ifdef SERIAL_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  localparam logic [3:0] DATA_LAST = 4'(WIDTH);

  logic [SYNC_STAGES-1:0] sync_shift, sync_ack, sync_data;
  logic                   prev_shift, prev_ack;
  logic                   strobe, ack, data;

  state_t           state, state_n;
  logic [3:0]       count, count_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [7:0]       word, word_n;
  logic             valid, valid_n;
  logic             error, error_n;
  logic             overrun, overrun_n;
`ifdef SERIAL_DESER_PARITY_EN
  logic             par_err, par_err_n;
`endif

  // Input synchronisers plus the previous synced level for press detection.
  always_ff @(posedge clk or negedge button0) begin
    if (!button0) begin
      sync_shift <= '0;
      sync_ack   <= '0;
      sync_data  <= '0;
      prev_shift <= 1'b0;
      prev_ack   <= 1'b0;
    end else begin
      sync_shift <= {sync_shift[SYNC_STAGES-2:0], button2};
      sync_ack   <= {sync_ack[SYNC_STAGES-2:0], button1};
      sync_data  <= {sync_data[SYNC_STAGES-2:0], switch8};
      prev_shift <= sync_shift[SYNC_STAGES-1];
      prev_ack   <= sync_ack[SYNC_STAGES-1];
    end
  end

  // Press = synced level falls from 1 to 0; held buttons produce one pulse only.
  assign strobe = prev_shift & ~sync_shift[SYNC_STAGES-1];
  assign ack    = prev_ack & ~sync_ack[SYNC_STAGES-1];
  assign data   = sync_data[SYNC_STAGES-1];

  // Frame state and display/status registers.
  always_ff @(posedge clk or negedge button0) begin
    if (!button0) begin
      state   <= IDLE;
      count   <= '0;
      shreg   <= '0;
      word    <= '0;
      valid   <= 1'b0;
      error   <= 1'b0;
      overrun <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      count   <= count_n;
      shreg   <= shreg_n;
      word    <= word_n;
      valid   <= valid_n;
      error   <= error_n;
      overrun <= overrun_n;
`ifdef SERIAL_DESER_PARITY_EN
      par_err <= par_err_n;
`endif
    end
  end

  // Next-state logic: ack clears flags first so a completing frame overrides it.
  always_comb begin
    state_n   = state;
    count_n   = count;
    shreg_n   = shreg;
    word_n    = word;
    valid_n   = valid;
    error_n   = error;
    overrun_n = overrun;
`ifdef SERIAL_DESER_PARITY_EN
    par_err_n = par_err;
`endif
    if (ack) begin
      valid_n   = 1'b0;
      error_n   = 1'b0;
      overrun_n = 1'b0;
    end
    if (strobe) begin
      case (state)
        IDLE: begin
          if (!data) begin
            state_n = DATA;
            count_n = '0;
            shreg_n = '0;
          end
        end
        DATA: begin
          for (int unsigned i = 0; i + 1 < WIDTH; i++) shreg_n[i] = shreg[i+1];
          shreg_n[WIDTH-1] = data;
          count_n = count + 4'd1;
          if (count_n == DATA_LAST) begin
`ifdef SERIAL_DESER_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
`ifdef SERIAL_DESER_PARITY_EN
        PARITY: begin
          par_err_n = (^shreg) ^ data;
          count_n   = count + 4'd1;
          state_n   = STOP;
        end
`endif
        STOP: begin
`ifdef SERIAL_DESER_PARITY_EN
          if (data && !par_err) begin
`else
          if (data) begin
`endif
            word_n             = '0;
            word_n[WIDTH-1:0]  = shreg;
            valid_n            = 1'b1;
            overrun_n          = !ack && (overrun || valid);
          end else begin
            error_n = 1'b1;
          end
          state_n = IDLE;
          count_n = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign ledR = word;
  assign ledG = {overrun, error, valid, (state != IDLE), count};

  hex_to_7seg u_hex_lo (.digit(word[3:0]), .seg(hex));
  hex_to_7seg u_hex_hi (.digit(word[7:4]), .seg(hex2));

endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser: directed frames against a frame-level model of the receiver.
module tb_serial_deser;

  localparam int unsigned WIDTH = 8;
`ifdef SERIAL_DESER_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif

  logic       clk = 1'b0;
  logic       button0 = 1'b0;
  logic       button2 = 1'b1;
  logic       button1 = 1'b1;
  logic       switch8 = 1'b1;
  logic [7:0] ledR, ledG;
  logic [6:0] hex, hex2;

  int checks = 0;
  int errors = 0;

  // Frame-level model: bits received so far plus the visible flags.
  bit         m_in_frame = 1'b0;
  bit         m_bits[$];
  logic [7:0] m_word = 8'h00;
  bit         m_valid = 1'b0, m_error = 1'b0, m_overrun = 1'b0;
  bit         settled = 1'b0;

  serial_deser #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .button0(button0), .button2(button2), .button1(button1),
    .switch8(switch8), .ledR(ledR), .ledG(ledG), .hex(hex), .hex2(hex2)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[d];
  endfunction

  function automatic logic [7:0] exp_ledg();
    logic [3:0] c;
    c = m_in_frame ? 4'(m_bits.size()) : 4'd0;
    return {m_overrun, m_error, m_valid, m_in_frame, c};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every settled cycle the DUT must agree with the model.
  always @(negedge clk) begin
    if (settled) begin
      check("ledR", ledR, m_word);
      check("ledG", ledG, exp_ledg());
      check("hex", {1'b0, hex}, {1'b0, seg7(m_word[3:0])});
      check("hex2", {1'b0, hex2}, {1'b0, seg7(m_word[7:4])});
    end
  end

  task automatic model_press(input bit d, input bit with_ack);
    logic [7:0] w;
    bit         par_ok;
    bit         done;
    w = 8'h00;
    par_ok = 1'b1;
    done = 1'b0;
    if (!m_in_frame) begin
      if (!d) begin
        m_in_frame = 1'b1;
        m_bits.delete();
      end
    end else if (m_bits.size() < NBITS) begin
      m_bits.push_back(d);
    end else begin
      done = 1'b1;
      for (int i = 0; i < int'(WIDTH); i++) w[i] = m_bits[i];
`ifdef SERIAL_DESER_PARITY_EN
      begin
        bit p;
        p = 1'b0;
        foreach (m_bits[i]) p ^= m_bits[i];
        par_ok = (p == 1'b0);
      end
`endif
      if (d && par_ok) begin
        m_word = w;
        if (with_ack) begin
          m_valid = 1'b1; m_overrun = 1'b0; m_error = 1'b0;
        end else begin
          m_overrun = m_overrun | m_valid;
          m_valid = 1'b1;
        end
      end else begin
        m_error = 1'b1;
        if (with_ack) begin
          m_valid = 1'b0; m_overrun = 1'b0;
        end
      end
      m_in_frame = 1'b0;
    end
    if (with_ack && !done) begin
      m_valid = 1'b0; m_error = 1'b0; m_overrun = 1'b0;
    end
  endtask

  // One button press held for several clocks; model updates once the DUT has taken it.
  task automatic press(input bit d, input bit with_ack);
    @(negedge clk); #2;
    settled = 1'b0;
    switch8 = d;
    button2 = 1'b0;
    if (with_ack) button1 = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    model_press(d, with_ack);
    settled = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    button2 = 1'b1;
    button1 = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic ack_press();
    @(negedge clk); #2;
    settled = 1'b0;
    button1 = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    m_valid = 1'b0; m_error = 1'b0; m_overrun = 1'b0;
    settled = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    button1 = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    settled = 1'b0;
    button0 = 1'b0;
    #1;
    check("reset ledR", ledR, 8'h00);
    check("reset ledG", ledG, 8'h00);
    check("reset hex", {1'b0, hex}, 8'h40);
    check("reset hex2", {1'b0, hex2}, 8'h40);
    m_in_frame = 1'b0; m_bits.delete(); m_word = 8'h00;
    m_valid = 1'b0; m_error = 1'b0; m_overrun = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    button0 = 1'b1;
    @(negedge clk);
    #1;
    settled = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] w, input bit stop, input bit ack_stop);
    press(1'b0, 1'b0);
    for (int i = 0; i < int'(WIDTH); i++) press(w[i], 1'b0);
`ifdef SERIAL_DESER_PARITY_EN
    press(^w, 1'b0);
`endif
    press(stop, ack_stop);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] w;
    do_reset();

    // Abort after three data bits.
    press(1'b0, 1'b0); press(1'b1, 1'b0); press(1'b0, 1'b0); press(1'b1, 1'b0);
    check("midframe ledG", ledG, 8'h13);
    do_reset();

    send_frame(8'hA5, 1'b1, 1'b0);
    check("A5 ledR", ledR, 8'hA5);
    check("A5 ledG", ledG, 8'h20);
    check("A5 hex", {1'b0, hex}, {1'b0, 7'b0010010});
    check("A5 hex2", {1'b0, hex2}, {1'b0, 7'b0001000});
    ack_press();
    check("ack ledG", ledG, 8'h00);

    // Idle-line strobes are ignored, then 0x3C with the full count pinned.
    repeat (3) press(1'b1, 1'b0);
    check("idle ledG", ledG, 8'h00);
    w = 8'h3C;
    press(1'b0, 1'b0);
    for (int i = 0; i < int'(WIDTH); i++) press(w[i], 1'b0);
    check("full count ledG", ledG, 8'h18);
`ifdef SERIAL_DESER_PARITY_EN
    press(^w, 1'b0);
`endif
    press(1'b1, 1'b0);
    check("3C ledR", ledR, 8'h3C);
    check("3C ledG", ledG, 8'h20);

    ack_press();
    send_frame(8'h0F, 1'b0, 1'b0);
    check("badstop ledR", ledR, 8'h3C);
    check("badstop ledG", ledG, 8'h40);
    ack_press();
    check("ack error ledG", ledG, 8'h00);

    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check("overrun ledR", ledR, 8'h22);
    check("overrun ledG", ledG, 8'hA0);
    check("22 hex", {1'b0, hex}, {1'b0, 7'b0100100});
    ack_press();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1);
    check("ack at stop ledG", ledG, 8'h20);

`ifdef SERIAL_DESER_PARITY_EN
    ack_press();
    w = 8'hA5;
    send_frame(w, 1'b1, 1'b0);
    check("parity ok ledR", ledR, 8'hA5);
    check("parity ok ledG", ledG, 8'h20);
    press(1'b0, 1'b0);
    for (int i = 0; i < int'(WIDTH); i++) press(w[i], 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("parity bad ledR", ledR, 8'hA5);
    check("parity bad ledG", ledG, 8'h60);
`endif

    settled = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_deser.md
Name: serial_deser

Overview:
- Receive side of the board's bit-serial link. The existing shift-register block sends LSB-first on button-strobed shifts; this block is the matching receiver.
- Samples a serial data switch on each debounced strobe press and frames the bits as start bit, data, stop bit.
- Shows the last good word on red LEDs and two seven-segment digits, and status on green LEDs.
- Top-level lab block; instantiates the existing hex-to-seven-segment decoder twice.

Parameters:
- WIDTH, 8, number of data bits per frame. Legal range 1..8. Unused high bits of the word read 0.
- SYNC_STAGES, 2, synchroniser depth for button and switch inputs. Minimum 2.

Ports:
- clk  in  1  system clock.
- button0  in  1  asynchronous active-low reset; clears all state immediately.
- button2  in  1  shift strobe, active-low pushbutton; one accepted bit per press.
- button1  in  1  acknowledge, active-low pushbutton; a press clears status flags.
- switch8  in  1  serial data line.
- ledR  out  8  last accepted word.
- ledG  out  8  status: [3:0] bit count, [4] busy, [5] valid, [6] error, [7] overrun.
- hex  out  7  segments for ledR[3:0], active-low, same encoding as the existing decoder.
- hex2  out  7  segments for ledR[7:4].

Behaviour:
- Reset is asynchronous and active-low on button0. All registers clear, including synchronisers.
  - State = IDLE. ledR = 0. ledG = 0. hex = hex2 = 7'b1000000.
- Synchronisers: button2, button1 and switch8 each pass through SYNC_STAGES flops.
  - strobe = one-cycle pulse when synced button2 goes 1 to 0 (press).
  - ack = the same edge detection on button1.
  - Data is the synced switch8, sampled in the strobe cycle.
- Latency: register updates land on the clk edge that samples strobe = 1. Response is visible the next cycle, 2–3 clk after the physical press.
- FSM states: IDLE, DATA, STOP.
- IDLE:
  - strobe with data = 0 (start bit): go to DATA, count = 0, shreg = 0, busy = 1.
  - strobe with data = 1: ignored (line idle).
- DATA, on each strobe:
  - shreg <= {data, shreg[WIDTH-1:1]}, i.e. LSB first.
  - count increments.
  - When count reaches WIDTH, go to STOP.
- STOP, on strobe:
  - data = 1: ledR <= shreg (zero-extended), valid <= 1. If valid was already 1 and no ack arrives in the same cycle, overrun <= 1.
  - data = 0: error <= 1, shreg discarded, ledR unchanged.
  - Either way: go to IDLE, busy = 0, count = 0.
- ack clears valid, error and overrun, and nothing else. It never affects the FSM or ledR.
- ack and frame completion in the same cycle: completion wins. valid = 1, overrun = 0, error reflects the new frame only.
- ledG[3:0] shows the live count (0..WIDTH). It saturates at WIDTH while in STOP.
- Reset mid-frame aborts the frame. Partial shreg contents never reach ledR.
- Strobes arrive slower than clk by construction. At most one bit is accepted per press, regardless of how long the button is held.

Optional Feature:
- Macro: SERIAL_DESER_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP. One strobe samples the parity bit.
  - Even parity: the XOR of the data bits and the parity bit must be 0.
  - On mismatch, error <= 1 after the stop bit is sampled, and the word is discarded even if the stop bit = 1.
  - ledG[3:0] counts up to WIDTH+1.
- Undefined: no parity state. Frame = start + WIDTH + stop strobes.

Test Plan:
- Reset, then check outputs: ledR = 0x00, ledG = 0x00, hex = hex2 = 7'b1000000. Assert button0 low mid-frame after 3 data bits → state IDLE, ledR still 0x00, count 0.
- Start 0, bits 1,0,1,0,0,1,0,1, stop 1 → ledR = 0xA5, ledG = 0x20, hex = 7'b0010010 ("5"), hex2 = 7'b0001000 ("A").
- Idle strobes with data = 1 (×3), then a full frame of 0x3C → first three ignored, ledR = 0x3C, ledG[4] = 1 during the data bits.
- Frame 0x0F with stop bit 0 → ledR keeps its previous value, ledG[6] = 1. Press button1 → ledG = 0x00.
- Two good frames 0x11 then 0x22 with no ack → ledR = 0x22, ledG[5] = 1, ledG[7] = 1. Repeat with ack pulsed in the stop-strobe cycle → ledG[7] = 0, ledG[5] = 1.
- With SERIAL_DESER_PARITY_EN: frame 0xA5 with parity bit 0 → accepted. Same frame with parity bit 1 and stop 1 → ledG[6] = 1, ledR unchanged.
